// File: rtl/multi_alarm_clock.sv
// 24-hour clock with several independent alarms, snooze and ring timeout.
// Time and alarm values are kept in binary and converted to BCD only for the
// display digits, so every wrap and carry is a plain binary compare.
module multi_alarm_clock #(
  parameter int CLK_HZ       = 100_000_000,
  parameter int NUM_ALARMS   = 4,
  parameter int SNOOZE_MIN   = 5,
  parameter int RING_MAX_MIN = 10,
  localparam int SEL_W       = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic [1:0]            mode,
  input  logic [SEL_W-1:0]      alarm_sel,
  input  logic [NUM_ALARMS-1:0] alarm_en,
  input  logic                  hour_up,
  input  logic                  min_up,
  input  logic                  snooze,
  input  logic                  alarm_off,
  output logic [3:0]            hr_MSB,
  output logic [3:0]            hr_LSB,
  output logic [3:0]            min_MSB,
  output logic [3:0]            min_LSB,
  output logic                  alarm,
  output logic [SEL_W-1:0]      alarm_id,
  output logic                  sec_tick
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  typedef enum logic [1:0] {
    MODE_RUN       = 2'b00,
    MODE_SET_TIME  = 2'b01,
    MODE_SET_ALARM = 2'b10,
    MODE_SHOW_SEC  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RINGING,
    ST_SNOOZED
  } state_e;

  // Binary 0..59 to two BCD digits.
  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    return {4'(v / 6'd10), 4'(v % 6'd10)};
  endfunction

  // Prescaler and second strobe
  logic [PW-1:0] pre_q;
  logic          sec_tick_q;
  logic          wrap;

  // Timekeeping
  logic [4:0] hr_q,  hr_d;
  logic [5:0] min_q, min_d;
  logic [5:0] sec_q, sec_d;
  logic       min_roll;
  logic       match_pt;

  // Alarm registers
  logic [4:0] al_hr_q  [NUM_ALARMS];
  logic [5:0] al_min_q [NUM_ALARMS];
  logic [4:0] al_hr_d  [NUM_ALARMS];
  logic [5:0] al_min_d [NUM_ALARMS];
  logic       sel_ok;

  // Button edge detection: {hour_up, min_up, snooze, alarm_off}
  logic [3:0] btn_q;
  logic [3:0] btn_rise;
  logic       hour_rise, min_rise, snooze_rise, off_rise;

  // Ring controller
  state_e           state_q, state_d;
  logic [5:0]       ring_cnt_q, ring_cnt_d;
  logic [SEL_W-1:0] id_q, id_d;
  logic [4:0]       wake_hr_q, wake_hr_d;
  logic [5:0]       wake_min_q, wake_min_d;
  logic             hit;
  logic [SEL_W-1:0] hit_id;
  logic [6:0]       wake_sum;
  logic [4:0]       snz_hr;
  logic [5:0]       snz_min;

  // Registered outputs
  logic             alarm_q, alarm_d;
  logic [SEL_W-1:0] alarm_id_q, alarm_id_d;

  // Display selection
  logic [5:0] disp_hi, disp_lo;

  assign wrap        = (pre_q == PW'(CLK_HZ - 1));
  assign btn_rise    = {hour_up, min_up, snooze, alarm_off} & ~btn_q;
  assign hour_rise   = btn_rise[3];
  assign min_rise    = btn_rise[2];
  assign snooze_rise = btn_rise[1];
  assign off_rise    = btn_rise[0];
  assign sel_ok      = (int'(alarm_sel) < NUM_ALARMS);
  // Alarms and snooze wake-ups are only evaluated on the tick that lands on :00 while running.
  assign match_pt    = min_roll && (mode == MODE_RUN);

  // Next time of day: frozen with seconds cleared while setting, otherwise advanced by the tick.
  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    sec_d    = sec_q;
    min_d    = min_q;
    hr_d     = hr_q;
    min_roll = 1'b0;
    if (mode == MODE_SET_TIME) begin
      sec_d = '0;
      if (min_rise)  min_d = (min_q == 6'd59) ? '0 : min_q + 6'd1;
      if (hour_rise) hr_d  = (hr_q == 5'd23) ? '0 : hr_q + 5'd1;
    end else if (wrap) begin
      if (sec_q == 6'd59) begin
        sec_d    = '0;
        min_roll = 1'b1;
        if (min_q == 6'd59) begin
          min_d = '0;
          hr_d  = (hr_q == 5'd23) ? '0 : hr_q + 5'd1;
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end
  end

  // Alarm editing applies the same stepping rules to the selected alarm.
  always_comb begin
    al_hr_d  = al_hr_q;
    al_min_d = al_min_q;
    if (mode == MODE_SET_ALARM && sel_ok) begin
      if (min_rise)
        al_min_d[alarm_sel] = (al_min_q[alarm_sel] == 6'd59) ? '0 : al_min_q[alarm_sel] + 6'd1;
      if (hour_rise)
        al_hr_d[alarm_sel] = (al_hr_q[alarm_sel] == 5'd23) ? '0 : al_hr_q[alarm_sel] + 5'd1;
    end
  end

  // Prescaler, time of day, alarm registers and button history.
  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  // NOTE: the alarm registers are a handful of flops whose reset value (00:00) is defined, so they are reset like any other state rather than treated as an unreset RAM.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      pre_q      <= '0;
      sec_tick_q <= 1'b0;
      hr_q       <= '0;
      min_q      <= '0;
      sec_q      <= '0;
      btn_q      <= '0;
      for (int k = 0; k < NUM_ALARMS; k++) begin
        al_hr_q[k]  <= '0;
        al_min_q[k] <= '0;
      end
    end else begin
      pre_q      <= wrap ? '0 : pre_q + PW'(1);
      sec_tick_q <= wrap;
      hr_q       <= hr_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      btn_q      <= {hour_up, min_up, snooze, alarm_off};
      al_hr_q    <= al_hr_d;
      al_min_q   <= al_min_d;
    end
  end

  // Lowest-index enabled alarm whose HH:MM equals the new time.
  always_comb begin
    hit    = 1'b0;
    hit_id = '0;
    for (int k = NUM_ALARMS - 1; k >= 0; k--) begin
      if (alarm_en[k] && al_hr_q[k] == hr_d && al_min_q[k] == min_d) begin
        hit    = 1'b1;
        hit_id = SEL_W'(k);
      end
    end
  end

  // Snooze wake time: current HH:MM plus the snooze length, wrapping through midnight.
  always_comb begin
    wake_sum = {1'b0, min_q} + 7'(SNOOZE_MIN);
    snz_hr   = hr_q;
    snz_min  = 6'(wake_sum);
    if (wake_sum >= 7'd60) begin
      snz_min = 6'(wake_sum - 7'd60);
      snz_hr  = (hr_q == 5'd23) ? '0 : hr_q + 5'd1;
    end
  end

  // Ring controller state register.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q    <= ST_IDLE;
      ring_cnt_q <= '0;
      id_q       <= '0;
      wake_hr_q  <= '0;
      wake_min_q <= '0;
    end else begin
      state_q    <= state_d;
      ring_cnt_q <= ring_cnt_d;
      id_q       <= id_d;
      wake_hr_q  <= wake_hr_d;
      wake_min_q <= wake_min_d;
    end
  end

  // Ring controller next state; alarm_off and a cleared enable dominate snooze and timeout.
  always_comb begin
    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
    id_d       = id_q;
    wake_hr_d  = wake_hr_q;
    wake_min_d = wake_min_q;
    unique case (state_q)
      ST_IDLE: begin
        if (match_pt && hit) begin
          state_d    = ST_RINGING;
          id_d       = hit_id;
          ring_cnt_d = '0;
        end
      end
      ST_RINGING: begin
        if (off_rise || !alarm_en[id_q]) begin
          state_d = ST_IDLE;
        end else if (snooze_rise) begin
          state_d    = ST_SNOOZED;
          wake_hr_d  = snz_hr;
          wake_min_d = snz_min;
        end else if (min_roll) begin
          if (ring_cnt_q + 6'd1 >= 6'(RING_MAX_MIN)) state_d = ST_IDLE;
          else ring_cnt_d = ring_cnt_q + 6'd1;
        end
      end
      ST_SNOOZED: begin
        if (off_rise || !alarm_en[id_q]) begin
          state_d = ST_IDLE;
        end else if (match_pt && hr_d == wake_hr_q && min_d == wake_min_q) begin
          state_d    = ST_RINGING;
          ring_cnt_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Ring controller outputs, decoded from the current state.
  always_comb begin
    alarm_d    = (state_q == ST_RINGING);
    alarm_id_d = (state_q == ST_IDLE) ? '0 : id_q;
  end

  // Output register for alarm and alarm_id.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      alarm_q    <= 1'b0;
      alarm_id_q <= '0;
    end else begin
      alarm_q    <= alarm_d;
      alarm_id_q <= alarm_id_d;
    end
  end

  // Display source per mode: HH:MM, selected alarm HH:MM, or MM:SS.
  always_comb begin
    disp_hi = {1'b0, hr_q};
    disp_lo = min_q;
    case (mode)
      MODE_SET_ALARM: begin
        disp_hi = sel_ok ? {1'b0, al_hr_q[alarm_sel]} : '0;
        disp_lo = sel_ok ? al_min_q[alarm_sel] : '0;
      end
      MODE_SHOW_SEC: begin
        disp_hi = min_q;
        disp_lo = sec_q;
      end
      default: ;
    endcase
  end

  assign {hr_MSB, hr_LSB}   = to_bcd(disp_hi);
  assign {min_MSB, min_LSB} = to_bcd(disp_lo);
  assign alarm              = alarm_q;
  assign alarm_id           = alarm_id_q;
  assign sec_tick           = sec_tick_q;

endmodule
